fifo_prog_sync: RTL and testbench
=================================

# fifo_prog_sync

Parametrised single-clock synchronous FIFO with arbitrary (non-power-of-2) depth, run-time programmable almost-full/almost-empty thresholds, an occupancy count output and a synchronous flush. It is the next generation of the team's 16x8 FIFO. It keeps the same handshake and status semantics (wr_ack, overflow, underflow, full/empty/almost flags) so existing scoreboards and monitors carry over. It sits between a producer and a consumer in any datapath that needs elastic buffering.

## Interface
- FIFO_WIDTH, 16, data word width (≥1)
- FIFO_DEPTH, 8, number of entries (≥2, need not be a power of 2)
- CNT_W, $clog2(FIFO_DEPTH+1), derived localparam: width of count and threshold ports
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of contents
- data_in  input  FIFO_WIDTH  write data
- wr_en  input  1  write request
- rd_en  input  1  read request
- afull_thresh  input  CNT_W  almostfull asserts when count ≥ this value
- aempty_thresh  input  CNT_W  almostempty asserts when count ≤ this value
- data_out  output  FIFO_WIDTH  registered read data
- wr_ack  output  1  registered: previous-cycle write accepted
- overflow  output  1  registered: previous-cycle write refused because full
- underflow  output  1  registered: previous-cycle read refused because empty
- full, empty, almostfull, almostempty  output  1  combinational from count
- count  output  CNT_W  current occupancy, 0..FIFO_DEPTH

## Operation
- Storage is FIFO_DEPTH x FIFO_WIDTH. wr_ptr and rd_ptr each run 0..FIFO_DEPTH-1 and wrap to 0 after FIFO_DEPTH-1 by explicit compare, never by natural overflow.
- Acceptance is evaluated on the pre-edge count:
  - write accepted iff wr_en && count < FIFO_DEPTH
  - read accepted iff rd_en && count > 0
- Write accepted: mem[wr_ptr] ← data_in, wr_ptr advances, wr_ack=1, overflow=0.
- Write refused: wr_ack=0; overflow=1 only if wr_en was asserted.
- Read accepted: data_out ← mem[rd_ptr], rd_ptr advances, underflow=0.
- Read refused: data_out holds; underflow=1 only if rd_en was asserted.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Full with wr_en && rd_en: read accepted, write refused (overflow=1), count drops by 1.
- Empty with wr_en && rd_en: write accepted, read refused (underflow=1), count rises by 1.
- Flags:
  - full = (count==FIFO_DEPTH)
  - empty = (count==0)
  - almostfull = (count ≥ afull_thresh)
  - almostempty = (count ≤ aempty_thresh)
- Threshold values are not range-checked. afull_thresh=0 keeps almostfull asserted; afull_thresh > FIFO_DEPTH keeps it deasserted.
- Flush has priority over wr_en and rd_en. On flush:
  - pointers and count go to 0
  - wr_ack, overflow, underflow go to 0
  - data_out holds
  - any concurrent write is dropped without raising overflow
- Memory contents are not cleared by reset or flush.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - data_out=0, wr_ack=0, overflow=0, underflow=0, count=0
  - empty=1, full=0, almostempty=1
  - almostfull = (afull_thresh==0)
- Write-to-read latency: a word written at edge N can be read at edge N+1, with data_out valid after edge N+1.
- count and all four flags reflect the state after the current edge. wr_ack, overflow and underflow are valid for the one cycle following the request edge.
- Reset deassertion mid-stream: the first edge with rst_n=1 behaves as from an empty FIFO.
- Threshold port changes take effect combinationally on the flags.

## Structure
- Package fifo_pkg holds:
  - a function computing CNT_W from depth
  - a typedef struct packed {wr_ack, overflow, underflow} fifo_resp_t, shared with the bench scoreboard
- Sub-module fifo_wrap_ptr #(DEPTH): an enable-driven pointer counter with a synchronous clear input and explicit wrap at DEPTH-1, instantiated once for wr_ptr and once for rd_ptr.
- The top level holds the memory array, the count register, the response registers and the flag logic.

## Test plan
- FIFO_DEPTH=6, FIFO_WIDTH=16. Write 0x0001..0x0006 back-to-back:
  - wr_ack=1 each cycle
  - count 1→6
  - full=1 after the 6th write
  - a 7th write gives overflow=1, wr_ack=0, count stays 6
- Read 6 words from full: data_out 0x0001..0x0006 in order, empty=1 after the 6th read. A 7th read gives underflow=1 and data_out holds 0x0006.
- Wrap: repeat 4 writes and 4 reads 5 times with FIFO_DEPTH=6. Every read matches the scoreboard and both pointers cross index 5→0.
- Simultaneous events:
  - at count=6 with wr_en=rd_en=1: overflow=1, count=5
  - at count=0 with wr_en=rd_en=1: underflow=1, wr_ack=1, count=1
  - at count=3 with wr_en=rd_en=1: count stays 3
- Thresholds: afull_thresh=4, aempty_thresh=1. almostfull rises exactly when count reaches 4 and almostempty falls when count reaches 2. Changing afull_thresh to 2 at count=3 asserts almostfull in the same cycle.
- Flush and reset:
  - flush at count=5 with wr_en=1: next count=0, empty=1, overflow=0, wr_ack=0, data_out unchanged
  - rst_n pulsed low mid-write: all outputs take their reset values immediately, without waiting for a clock edge

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared sizing helpers and the handshake response record
//                for the programmable synchronous FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

   // Width needed to hold an occupancy of 0..depth inclusive.
   function automatic int calc_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of a pointer that runs 0..depth-1; never narrower than one bit.
   function automatic int calc_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Per-request handshake response, valid the cycle after the request edge.
   typedef struct packed {
      logic wr_ack;
      logic overflow;
      logic underflow;
   } fifo_resp_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_wrap_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wrap_ptr
//  Description : Enable-driven pointer counter 0..DEPTH-1 with synchronous
//                clear. Wraps by explicit compare so DEPTH need not be a
//                power of two.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_wrap_ptr
   import fifo_pkg::*;
#(
   parameter int   DEPTH = 8,
   localparam int  PTR_W = calc_ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] c_ONE  = PTR_W'(1);

   logic [PTR_W-1:0] r_ptr;

   // Advance on enable, returning to 0 after the last valid index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (clr) begin
         r_ptr <= '0;
      end else if (en) begin
         r_ptr <= (r_ptr == c_LAST) ? '0 : (r_ptr + c_ONE);
      end
   end

   assign ptr = r_ptr;

endmodule : fifo_wrap_ptr
`default_nettype wire

// File: rtl/fifo_prog_sync.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_prog_sync
//  Description : Single-clock FIFO of arbitrary depth with programmable
//                almost-full/almost-empty thresholds, occupancy count,
//                registered handshake responses and synchronous flush.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_prog_sync
   import fifo_pkg::*;
#(
   parameter int   FIFO_WIDTH = 16,
   parameter int   FIFO_DEPTH = 8,
   localparam int  CNT_W      = calc_cnt_w(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [CNT_W-1:0]      afull_thresh,
   input  logic [CNT_W-1:0]      aempty_thresh,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CNT_W-1:0]      count
);

   localparam int               c_PTR_W = calc_ptr_w(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [FIFO_WIDTH-1:0] r_data_out;
   logic [CNT_W-1:0]      r_count;
   fifo_resp_t            r_resp;
   logic [c_PTR_W-1:0]    w_wr_ptr;
   logic [c_PTR_W-1:0]    w_rd_ptr;
   logic                  w_wr_go;
   logic                  w_rd_go;

   // Acceptance is judged on the pre-edge count; flush suppresses both sides.
   assign w_wr_go = wr_en && !flush && (r_count != c_DEPTH);
   assign w_rd_go = rd_en && !flush && (r_count != '0);

   fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .en    (w_wr_go),
      .ptr   (w_wr_ptr)
   );

   fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .en    (w_rd_go),
      .ptr   (w_rd_ptr)
   );

   // Storage is never cleared; only accepted writes touch it.
   always_ff @(posedge clk) begin
      if (w_wr_go) begin
         r_mem[w_wr_ptr] <= data_in;
      end
   end

   // Read data register holds its value unless a read is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out <= '0;
      end else if (w_rd_go) begin
         r_data_out <= r_mem[w_rd_ptr];
      end
   end

   // Occupancy: a concurrent accepted read and write cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else begin
         case ({w_wr_go, w_rd_go})
            2'b10:   r_count <= r_count + c_ONE;
            2'b01:   r_count <= r_count - c_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // One-cycle handshake responses; a write dropped by flush is not an overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp <= '0;
      end else if (flush) begin
         r_resp <= '0;
      end else begin
         r_resp.wr_ack    <= w_wr_go;
         r_resp.overflow  <= wr_en && !w_wr_go;
         r_resp.underflow <= rd_en && !w_rd_go;
      end
   end

   assign data_out    = r_data_out;
   assign wr_ack      = r_resp.wr_ack;
   assign overflow    = r_resp.overflow;
   assign underflow   = r_resp.underflow;
   assign count       = r_count;
   assign full        = (r_count == c_DEPTH);
   assign empty       = (r_count == '0);
   assign almostfull  = (r_count >= afull_thresh);
   assign almostempty = (r_count <= aempty_thresh);

endmodule : fifo_prog_sync
`default_nettype wire

// File: tb/tb_fifo_prog_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_prog_sync
//  Description : Self-checking bench for fifo_prog_sync (depth 6, width 16)
//                against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_prog_sync;
   import fifo_pkg::*;

   localparam int W  = 16;
   localparam int D  = 6;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic [W-1:0]  data_in;
   logic          wr_en;
   logic          rd_en;
   logic [CW-1:0] afull_thresh;
   logic [CW-1:0] aempty_thresh;
   logic [W-1:0]  data_out;
   logic          wr_ack, overflow, underflow;
   logic          full, empty, almostfull, almostempty;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_dout;
   fifo_resp_t   m_resp;

   fifo_prog_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .data_in       (data_in),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .afull_thresh  (afull_thresh),
      .aempty_thresh (aempty_thresh),
      .data_out      (data_out),
      .wr_ack        (wr_ack),
      .overflow      (overflow),
      .underflow     (underflow),
      .full          (full),
      .empty         (empty),
      .almostfull    (almostfull),
      .almostempty   (almostempty),
      .count         (count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_q.delete();
      m_dout = '0;
      m_resp = '0;
   endtask

   // Drive one clock's worth of requests, advance the model, settle 1 ns past the edge.
   task automatic cycle(input logic f, input logic w, input logic r, input logic [W-1:0] d);
      bit wok, rok;
      flush = f; wr_en = w; rd_en = r; data_in = d;
      @(posedge clk);
      if (f) begin
         m_q.delete();
         m_resp = '0;
      end else begin
         wok = w && (m_q.size() < D);
         rok = r && (m_q.size() > 0);
         if (rok) m_dout = m_q.pop_front();
         if (wok) m_q.push_back(d);
         m_resp.wr_ack    = wok;
         m_resp.overflow  = w && !wok;
         m_resp.underflow = r && !rok;
      end
      #1;
      flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 0; wr_en = 0; rd_en = 0; data_in = '0;
      afull_thresh = 3'd4; aempty_thresh = 3'd1;
      model_reset();
      #2;
      n_checks++;
      if ({data_out, wr_ack, overflow, underflow, count} !== {16'h0, 3'b000, 3'd0}) begin
         n_fail++; $display("FAIL reset_regs: got %h/%b%b%b/%0d want 0/000/0", data_out, wr_ack, overflow, underflow, count);
      end
      n_checks++;
      if ({empty, full, almostempty, almostfull} !== 4'b1010) begin
         n_fail++; $display("FAIL reset_flags: got e%b f%b ae%b af%b want 1010", empty, full, almostempty, almostfull);
      end
      afull_thresh = 3'd0; #1;
      n_checks++;
      if (almostfull !== 1'b1) begin
         n_fail++; $display("FAIL reset_af_thr0: got %b want 1", almostfull);
      end
      afull_thresh = 3'd4;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= D; i++) begin
         cycle(0, 1, 0, W'(i));
         n_checks++;
         if (wr_ack !== 1'b1 || count !== CW'(i)) begin
            n_fail++; $display("FAIL fill_%0d: got ack=%b count=%0d want ack=1 count=%0d", i, wr_ack, count, i);
         end
      end
      n_checks++;
      if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
      cycle(0, 1, 0, 16'h0007);
      n_checks++;
      if ({overflow, wr_ack, count} !== {1'b1, 1'b0, 3'd6}) begin
         n_fail++; $display("FAIL overflow: got ovf=%b ack=%b count=%0d want 1 0 6", overflow, wr_ack, count);
      end
   endtask

   task automatic test_drain_underflow();
      for (int i = 1; i <= D; i++) begin
         cycle(0, 0, 1, '0);
         n_checks++;
         if (data_out !== W'(i)) begin
            n_fail++; $display("FAIL drain_%0d: got %h want %h", i, data_out, W'(i));
         end
      end
      n_checks++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL empty_flag: got %b want 1", empty); end
      cycle(0, 0, 1, '0);
      n_checks++;
      if ({underflow, data_out} !== {1'b1, 16'h0006}) begin
         n_fail++; $display("FAIL underflow: got udf=%b dout=%h want 1 0006", underflow, data_out);
      end
   endtask

   task automatic test_wrap();
      for (int rep = 0; rep < 5; rep++) begin
         for (int i = 0; i < 4; i++) cycle(0, 1, 0, W'($urandom));
         for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, '0);
            n_checks++;
            if (data_out !== m_dout) begin
               n_fail++; $display("FAIL wrap_r%0d_%0d: got %h want %h", rep, i, data_out, m_dout);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      cycle(1, 0, 0, '0);
      for (int i = 0; i < D; i++) cycle(0, 1, 0, W'($urandom));
      cycle(0, 1, 1, 16'hBEEF);
      n_checks++;
      if ({overflow, wr_ack, count, data_out} !== {1'b1, 1'b0, 3'd5, m_dout}) begin
         n_fail++; $display("FAIL sim_full: got ovf=%b ack=%b cnt=%0d dout=%h want 1 0 5 %h", overflow, wr_ack, count, data_out, m_dout);
      end
      cycle(1, 0, 0, '0);
      cycle(0, 1, 1, 16'h1234);
      n_checks++;
      if ({underflow, wr_ack, count} !== {1'b1, 1'b1, 3'd1}) begin
         n_fail++; $display("FAIL sim_empty: got udf=%b ack=%b cnt=%0d want 1 1 1", underflow, wr_ack, count);
      end
      cycle(0, 1, 0, 16'h2222);
      cycle(0, 1, 0, 16'h3333);
      cycle(0, 1, 1, 16'h4444);
      n_checks++;
      if ({count, wr_ack, underflow, overflow, data_out} !== {3'd3, 1'b1, 1'b0, 1'b0, 16'h1234}) begin
         n_fail++; $display("FAIL sim_mid: got cnt=%0d ack=%b udf=%b ovf=%b dout=%h want 3 1 0 0 1234", count, wr_ack, underflow, overflow, data_out);
      end
   endtask

   task automatic test_thresholds();
      cycle(1, 0, 0, '0);
      afull_thresh = 3'd4; aempty_thresh = 3'd1;
      for (int i = 1; i <= 4; i++) begin
         cycle(0, 1, 0, W'(i));
         n_checks++;
         if (almostfull !== (i >= 4) || almostempty !== (i <= 1)) begin
            n_fail++; $display("FAIL thr_cnt%0d: got af=%b ae=%b want af=%b ae=%b", i, almostfull, almostempty, (i >= 4), (i <= 1));
         end
      end
      cycle(0, 0, 1, '0);
      n_checks++;
      if (almostfull !== 1'b0) begin n_fail++; $display("FAIL thr_af_cnt3: got %b want 0", almostfull); end
      afull_thresh = 3'd2; #1;
      n_checks++;
      if (almostfull !== 1'b1) begin n_fail++; $display("FAIL thr_af_change: got %b want 1", almostfull); end
      afull_thresh = 3'd7; aempty_thresh = 3'd0;
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, W'(i));
      n_checks++;
      if ({full, almostfull} !== 2'b10) begin n_fail++; $display("FAIL thr_af_above_depth: got full=%b af=%b want 1 0", full, almostfull); end
      afull_thresh = 3'd4; aempty_thresh = 3'd1;
   endtask

   task automatic test_flush();
      logic [W-1:0] held;
      cycle(1, 0, 0, '0);
      for (int i = 0; i < D; i++) cycle(0, 1, 0, W'(16'hA000 + i));
      cycle(0, 0, 1, '0);
      held = 16'hA000;
      cycle(1, 1, 0, 16'hDEAD);
      n_checks++;
      if ({count, empty, overflow, wr_ack, data_out} !== {3'd0, 1'b1, 1'b0, 1'b0, held}) begin
         n_fail++; $display("FAIL flush: got cnt=%0d e=%b ovf=%b ack=%b dout=%h want 0 1 0 0 %h", count, empty, overflow, wr_ack, data_out, held);
      end
   endtask

   task automatic test_async_reset();
      cycle(0, 1, 0, 16'h0101);
      cycle(0, 1, 1, 16'h0202);
      wr_en = 1'b1; data_in = 16'h0303;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({data_out, wr_ack, overflow, underflow, count, empty, full, almostempty, almostfull}
          !== {16'h0, 3'b000, 3'd0, 1'b1, 1'b0, 1'b1, (afull_thresh == 3'd0)}) begin
         n_fail++; $display("FAIL async_reset: got dout=%h ack=%b cnt=%0d e=%b f=%b ae=%b af=%b want 0 0 0 1 0 1 0", data_out, wr_ack, count, empty, full, almostempty, almostfull);
      end
      wr_en = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      cycle(0, 1, 1, 16'h0404);
      n_checks++;
      if ({count, wr_ack, underflow} !== {3'd1, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL post_reset: got cnt=%0d ack=%b udf=%b want 1 1 1", count, wr_ack, underflow);
      end
   endtask

   task automatic test_random();
      logic [W+10-1:0] exp, act;
      int n;
      for (int k = 0; k < 400; k++) begin
         afull_thresh  = CW'($urandom_range(0, 7));
         aempty_thresh = CW'($urandom_range(0, 7));
         cycle(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom_range(0, 1), W'($urandom));
         n = m_q.size();
         exp = {m_dout, m_resp.wr_ack, m_resp.overflow, m_resp.underflow,
                (n == D), (n == 0), (n >= int'(afull_thresh)), (n <= int'(aempty_thresh)), CW'(n)};
         act = {data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty, count};
         n_checks++;
         if (act !== exp) begin
            n_fail++; $display("FAIL random_%0d: got %h want %h", k, act, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_wrap();
      test_simultaneous();
      test_thresholds();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Hard stop so the run always ends even if a task stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within 200000 ns");
      $fatal(1);
   end

endmodule : tb_fifo_prog_sync
`default_nettype wire
